// File: rtl/dmem_access_ctrl.sv
// Arbiter and sequencer sharing one single-port synchronous data RAM between
// the Memory-stage CPU port and the debug/program-loader port.
//
// state    | meaning
// S_IDLE   | arbitrate between unmasked requests, latch the winner's access
// S_ACCESS | strobe the RAM for an aligned access, or flag a misaligned one
// S_WAIT   | down-count the RAM read latency, capture read data at terminal count
// S_DONE   | one-cycle done/err pulse to the grantee
module dmem_access_ctrl #(
  parameter int WORD        = 64,
  parameter int MEM_LATENCY = 2,
  parameter int OFS_W       = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cpu_mem_read,
  input  logic            i_cpu_mem_write,
  input  logic [WORD-1:0] i_cpu_addr,
  input  logic [WORD-1:0] i_cpu_wdata,
  output logic [WORD-1:0] o_cpu_rdata,
  output logic            o_cpu_done,
  output logic            o_cpu_err,
  output logic            o_cpu_stall,
  input  logic            i_dbg_req,
  input  logic            i_dbg_we,
  input  logic [WORD-1:0] i_dbg_addr,
  input  logic [WORD-1:0] i_dbg_wdata,
  output logic [WORD-1:0] o_dbg_rdata,
  output logic            o_dbg_done,
  output logic            o_dbg_err,
  output logic            o_ram_en,
  output logic            o_ram_we,
  output logic [WORD-1:0] o_ram_addr,
  output logic [WORD-1:0] o_ram_wdata,
  input  logic [WORD-1:0] i_ram_rdata,
  output logic            o_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_gnt_cpu;
  logic            r_last_cpu;
  logic            r_served;
  logic            r_we;
  logic            r_err;
  logic [WORD-1:0] r_addr;
  logic [WORD-1:0] r_wdata;
  logic [WORD-1:0] r_cpu_rdata;
  logic [WORD-1:0] r_dbg_rdata;
  logic [3:0]      r_cnt;

  logic w_cpu_req;
  logic w_cpu_vis;
  logic w_dbg_vis;
  logic w_grant;
  logic w_pick_cpu;
  logic w_aligned;
  logic w_cnt_tc;
  logic w_ram_en;
  logic w_ram_we;
  logic w_cpu_done;
  logic w_dbg_done;

  assign w_cpu_req  = i_cpu_mem_read | i_cpu_mem_write;
  // r_served is high only in the first IDLE cycle after DONE; it hides the
  // requester just served so the other side gets a chance.
  assign w_cpu_vis  = w_cpu_req & ~(r_served & r_gnt_cpu);
  assign w_dbg_vis  = i_dbg_req & ~(r_served & ~r_gnt_cpu);
  assign w_grant    = (r_state == S_IDLE) & (w_cpu_vis | w_dbg_vis);
  assign w_pick_cpu = w_cpu_vis & (~w_dbg_vis | ~r_last_cpu);
  assign w_aligned  = (r_addr[OFS_W-1:0] == '0);
  assign w_cnt_tc   = (r_cnt == 4'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_aligned) begin
          w_ram_en = 1'b1;
          w_ram_we = r_we;
          // Reads always pass through WAIT so the data is captured at the
          // end of cycle A+MEM_LATENCY, including MEM_LATENCY==1.
          w_state_nxt = r_we ? S_DONE : S_WAIT;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_WAIT: begin
        if (w_cnt_tc) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt_cpu   <= 1'b0;
      r_last_cpu  <= 1'b0;
      r_served    <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
      r_cnt       <= 4'd0;
    end else begin
      r_served <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_gnt_cpu  <= w_pick_cpu;
            r_last_cpu <= w_pick_cpu;
            r_we       <= w_pick_cpu ? i_cpu_mem_write : i_dbg_we;
            r_addr     <= w_pick_cpu ? i_cpu_addr : i_dbg_addr;
            r_wdata    <= w_pick_cpu ? i_cpu_wdata : i_dbg_wdata;
            r_err      <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (!w_aligned) begin
            r_err <= 1'b1;
            if (!r_we) begin
              if (r_gnt_cpu) r_cpu_rdata <= '0;
              else           r_dbg_rdata <= '0;
            end
          end else if (!r_we) begin
            r_cnt <= LAT_M1;
          end
        end
        S_WAIT: begin
          if (w_cnt_tc) begin
            if (r_gnt_cpu) r_cpu_rdata <= i_ram_rdata;
            else           r_dbg_rdata <= i_ram_rdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_cpu_done  = (r_state == S_DONE) &  r_gnt_cpu;
  assign w_dbg_done  = (r_state == S_DONE) & ~r_gnt_cpu;

  assign o_cpu_done  = w_cpu_done;
  assign o_cpu_err   = w_cpu_done & r_err;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_stall = w_cpu_req & ~w_cpu_done;
  assign o_dbg_done  = w_dbg_done;
  assign o_dbg_err   = w_dbg_done & r_err;
  assign o_dbg_rdata = r_dbg_rdata;
  assign o_ram_en    = w_ram_en;
  assign o_ram_we    = w_ram_we;
  assign o_ram_addr  = r_addr;
  assign o_ram_wdata = r_wdata;
  assign o_busy      = (r_state != S_IDLE);

endmodule
